transient_timer_arbiter: RTL and testbench
==========================================

TRANSIENT_TIMER_ARBITER -- requirements
Module: transient_timer_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, the number of requesting monitor channels.
REQ-002 SHALL have parameter CNT_W, default 18, the hold-off counter width; this holds SCALE*15 = 150000.
REQ-003 SHALL have parameter SCALE, default 10000, the clock ticks per delay step (1 s per step at 10 kHz).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  system clock (10 kHz nominal); all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 req  input  N_CH  per-channel level request for the shared transient timer; held high until done or abandonment.
REQ-008 delay_sel  input  4  hold-off step count, sampled only in the grant cycle.
REQ-009 grant  output  N_CH  one-hot owner of the timer; all zero when no channel owns it.
REQ-010 busy  output  1  high while any grant bit is set.
REQ-011 done  output  N_CH  one-cycle pulse to the owning channel when its hold-off has expired.
REQ-012 remaining  output  CNT_W  current counter value; zero when idle.

Function
REQ-013 SHALL implement the states IDLE, COUNT and DONE, held in a registered state variable.
REQ-014 IDLE: if any req bit is high, SHALL grant one channel, load counter = SCALE*delay_sel and enter COUNT on the same edge; otherwise stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: the search starts at the channel after the last granted channel (aborted grants included), and channel 0 has priority after reset.
REQ-016 Grant latency SHALL be one edge: req sampled high at edge t gives grant visible after edge t.
REQ-017 COUNT: if req of the owning channel is low, SHALL clear grant, clear counter and return to IDLE with no done pulse (abort).
REQ-018 COUNT: otherwise, if counter == 0, SHALL enter DONE.
REQ-019 COUNT: otherwise SHALL decrement counter by 1; the counter SHALL never wrap below zero.
REQ-020 DONE: SHALL assert done for the owner for exactly one cycle, clear grant, update the round-robin pointer and return to IDLE.
REQ-021 done SHALL rise exactly SCALE*delay_sel+1 cycles after grant rises; delay_sel=0 gives done 1 cycle after grant.
REQ-022 Grant SHALL remain stable for the whole of COUNT; req changes on non-owning channels SHALL have no effect until the next IDLE.
REQ-023 A channel whose req stays high after done SHALL re-compete in the next IDLE cycle under round-robin; an uncontested channel is re-granted.
REQ-024 SHALL spend a minimum of one IDLE cycle between consecutive grants.
REQ-025 Multiplication SCALE*delay_sel SHALL be computed at CNT_W bits with no truncation for delay_sel up to 15.
REQ-026 Changes to delay_sel during COUNT SHALL be ignored.

Reset
REQ-027 Reset SHALL force IDLE, grant=0, done=0, busy=0, remaining=0 and the round-robin pointer to the channel-0 position, immediately and independent of clk.
REQ-028 Reset asserted mid-COUNT SHALL abort without a done pulse; after release the first grant SHALL follow REQ-015 with channel 0 first.

Structure
REQ-029 SHALL place the state encoding (IDLE/COUNT/DONE), the CNT_W default and the SCALE default in the shared package monitor_pkg.
REQ-030 SHALL implement round-robin selection in a combinational sub-module rr_arbiter (inputs req and pointer; output one-hot pick).
REQ-031 The RTL SHALL be 120-400 lines in total, with no latches and all outputs driven from registers except busy.

Verification (bench uses SCALE=4)
REQ-032 Single request: req=0001, delay_sel=3 -> grant=0001 after 1 edge, done[0] pulse 13 cycles after grant, grant clears with done.
REQ-033 Zero delay: req=0010, delay_sel=0 -> done[1] exactly 1 cycle after grant, remaining stays 0.
REQ-034 Round-robin: req=1111 held, delay_sel=1 -> grant sequence 0001, 0010, 0100, 1000, 0001, each grant separated by one IDLE cycle.
REQ-035 Abort: req=0100, delay_sel=5, drop req[2] 6 cycles after grant -> grant=0 next edge, no done, the next request is granted after that.
REQ-036 Reset mid-COUNT: reset asserted with remaining=10 -> all outputs 0 without waiting for a clk edge; after release, req=1001 -> grant=0001.
REQ-037 Full scale: SCALE=10000, delay_sel=15 -> remaining loads 150000 and done arrives 150001 cycles after grant.

Source files
------------

// File: rtl/monitor_pkg.sv
`default_nettype none
// ============================================================================
// monitor_pkg : shared encodings and defaults for the transient timer arbiter
// Rev 1.0
// ============================================================================
package monitor_pkg;

    localparam int CNT_W_DEF = 18;
    localparam int SCALE_DEF = 10000;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_COUNT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // A single channel still needs a one-bit pointer.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, search starts after ptr
// Rev 1.0
// ============================================================================
module rr_arbiter
    import monitor_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int PTR_W = ptr_w(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_CH-1:0]  pick,
    output logic [PTR_W-1:0] pick_idx
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        pick     = '0;
        pick_idx = ptr;
        idx      = '0;
        found    = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N_CH);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                pick_idx  = idx;
                found     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/transient_timer_arbiter.sv
`default_nettype none
// ============================================================================
// transient_timer_arbiter : round-robin owner of one shared hold-off timer
// Rev 1.0
// ============================================================================
module transient_timer_arbiter
    import monitor_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = CNT_W_DEF,
    parameter int SCALE = SCALE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  req,
    input  logic [3:0]       delay_sel,
    output logic [N_CH-1:0]  grant,
    output logic             busy,
    output logic [N_CH-1:0]  done,
    output logic [CNT_W-1:0] remaining
);

    localparam int PTR_W = ptr_w(N_CH);

    state_t           state_q, state_d;
    logic [N_CH-1:0]  grant_q, grant_d;
    logic [N_CH-1:0]  done_q,  done_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [PTR_W-1:0] ptr_q,   ptr_d;

    logic [N_CH-1:0]  pick;
    logic [PTR_W-1:0] pick_idx;
    logic [CNT_W-1:0] cnt_load;
    logic             owner_req;

    rr_arbiter #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_rr (
        .req      (req),
        .ptr      (ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // Both operands widened before multiplying so 15*SCALE cannot truncate.
    assign cnt_load  = CNT_W'(SCALE) * CNT_W'(delay_sel);
    assign owner_req = |(req & grant_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= PTR_W'(N_CH - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|req) state_d = ST_COUNT;
            ST_COUNT: begin
                if (!owner_req)       state_d = ST_IDLE;
                else if (cnt_q == '0) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Pointer moves at grant time, so aborted owners also lose priority.
    always_comb begin
        grant_d = grant_q;
        done_d  = '0;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    cnt_d   = cnt_load;
                    ptr_d   = pick_idx;
                end else begin
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_COUNT: begin
                if (!owner_req) begin
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    done_d  = grant_q;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign remaining = cnt_q;
    assign busy      = |grant_q;

endmodule
`default_nettype wire

// File: tb/tb_transient_timer_arbiter.sv
`default_nettype none
// ============================================================================
// tb_transient_timer_arbiter : directed scoreboard bench (SCALE=4)
// Rev 1.0
// ============================================================================
module tb_transient_timer_arbiter;

    localparam int N_CH  = 4;
    localparam int CNT_W = 18;
    localparam int SCALE = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N_CH-1:0]  req = '0;
    logic [3:0]       delay_sel = '0;
    logic [N_CH-1:0]  grant, done;
    logic             busy;
    logic [CNT_W-1:0] remaining;

    logic [1:0]       req_f = '0;
    logic [3:0]       delay_f = '0;
    logic [1:0]       grant_f, done_f;
    logic             busy_f;
    logic [17:0]      remaining_f;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [N_CH-1:0] grant;
        int              lat;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    transient_timer_arbiter #(.N_CH(N_CH), .CNT_W(CNT_W), .SCALE(SCALE)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .delay_sel (delay_sel),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    transient_timer_arbiter #(.N_CH(2), .CNT_W(18), .SCALE(10000)) u_full (
        .clk       (clk),
        .reset     (reset),
        .req       (req_f),
        .delay_sel (delay_f),
        .grant     (grant_f),
        .busy      (busy_f),
        .done      (done_f),
        .remaining (remaining_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each new grant pops the next expected owner and done latency
    // (-1 means the grant must end without any done pulse).
    logic [N_CH-1:0] prev_grant = '0;
    int              grant_cyc  = 0;
    int              cur_lat    = -1;
    always @(negedge clk) begin
        exp_t e;
        if (grant !== '0 && prev_grant === '0) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_grant", 32'(grant), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_grant", 32'(grant), 32'(e.grant));
                cur_lat   = e.lat;
                grant_cyc = cyc;
            end
        end
        if (done !== '0) begin
            check("sb_done_owner", 32'(done), 32'(grant));
            check("sb_done_latency", 32'(cyc - grant_cyc), 32'(cur_lat));
        end
        prev_grant = grant;
    end

    task automatic wait_done(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done !== '0) seen = 1'b1;
        end
        if (!seen) check("wait_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_grant(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (grant !== '0) seen = 1'b1;
        end
        if (!seen) check("wait_grant_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Round-robin from a fresh pointer, delay 1 -> done 5 cycles after grant
        exp_q.push_back('{4'b0001, 5});
        exp_q.push_back('{4'b0010, 5});
        exp_q.push_back('{4'b0100, 5});
        exp_q.push_back('{4'b1000, 5});
        exp_q.push_back('{4'b0001, 5});
        req = 4'b1111;
        delay_sel = 4'd1;
        for (int k = 0; k < 5; k++) begin
            wait_done(20);
            if (k == 4) req = '0;
            @(negedge clk);
            check("rr_idle_gap", 32'(grant), 32'd0);
        end

        // Single request, delay 3 -> done 13 cycles after grant
        exp_q.push_back('{4'b0001, 13});
        req = 4'b0001;
        delay_sel = 4'd3;
        wait_grant(5);
        check("single_busy", 32'(busy), 32'd1);
        check("single_remaining_load", 32'(remaining), 32'd12);
        wait_done(20);
        check("single_grant_at_done", 32'(grant), 32'b0001);
        req = '0;
        @(negedge clk);
        check("single_grant_clear", 32'(grant), 32'd0);
        check("single_done_pulse", 32'(done), 32'd0);

        // Zero delay
        exp_q.push_back('{4'b0010, 1});
        req = 4'b0010;
        delay_sel = 4'd0;
        wait_grant(5);
        check("zero_remaining", 32'(remaining), 32'd0);
        wait_done(5);
        check("zero_remaining_done", 32'(remaining), 32'd0);
        req = '0;
        @(negedge clk);

        // Abort after 6 cycles; delay_sel change mid-count must be ignored
        exp_q.push_back('{4'b0100, -1});
        req = 4'b0100;
        delay_sel = 4'd5;
        wait_grant(5);
        delay_sel = 4'd0;
        repeat (6) @(negedge clk);
        check("abort_remaining", 32'(remaining), 32'd14);
        req = '0;
        @(negedge clk);
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_remaining_clr", 32'(remaining), 32'd0);
        exp_q.push_back('{4'b1000, 1});
        req = 4'b1000;
        wait_done(10);
        req = '0;
        @(negedge clk);

        // Reset mid-count, asynchronous
        exp_q.push_back('{4'b0010, -1});
        req = 4'b0010;
        delay_sel = 4'd3;
        wait_grant(5);
        repeat (2) @(negedge clk);
        check("midrst_remaining", 32'(remaining), 32'd10);
        #2 reset = 1'b1;
        #1;
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_remaining0", 32'(remaining), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back('{4'b0001, 1});
        req = 4'b1001;
        delay_sel = 4'd0;
        wait_done(10);
        req = '0;
        @(negedge clk);

        // Full scale load on the SCALE=10000 instance
        req_f = 2'b01;
        delay_f = 4'd15;
        @(negedge clk);
        check("full_grant", 32'(grant_f), 32'd1);
        check("full_load", 32'(remaining_f), 32'd150000);
        @(negedge clk);
        check("full_decrement", 32'(remaining_f), 32'd149999);
        req_f = '0;
        @(negedge clk);
        check("full_abort", 32'(grant_f), 32'd0);
        check("full_done", 32'(done_f), 32'd0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
